// File: rtl/multicycle_control.sv
// multicycle_control
//   Finite-state sequencer for the time-shared multicycle MIPS datapath
//   (one ALU, one memory). It steps each instruction through fetch,
//   decode, execute, memory and writeback, one phase per clock. Memory
//   phases wait on a mem_ready handshake. The block also counts retired
//   instructions and latches a sticky flag when it decodes an unsupported
//   opcode.
//
//   Build option: define MC_ADDI_EN to decode addi (opcode 001000).
//   Without it, addi is treated as an illegal opcode.
//
// Ports
//   clock        rising-edge system clock
//   reset_n      asynchronous active-low reset
//   run          level; keep executing, sampled at instruction boundaries
//   Opcode[5:0]  instruction[31:26] from the instruction register
//   mem_ready    memory finishes the current read/write this cycle
//   Zero         ALU zero flag; the datapath gates it with PCWriteCond
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegWrite, RegDst, ALUSrcA     single-bit datapath controls
//   ALUSrcB[1:0]  00 B reg, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUOp[1:0]    00 add, 01 sub, 10 funct-decoded
//   PCSource[1:0] 00 ALU result, 01 ALUOut reg, 10 jump target
//   state[3:0]    current state encoding (debug)
//   illegal_op    sticky; an unsupported opcode was decoded
//   instr_count   16-bit retired-instruction counter, wraps

module multicycle_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [5:0]  Opcode,
  input  logic        mem_ready,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10,
`ifdef MC_ADDI_EN
    ADDIEX = 4'd11,
    ADDIWB = 4'd12,
`endif
    HALT   = 4'd13
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        illegal_q;
  logic [15:0] count_q;
  logic        retire;

  // Zero is consumed in the datapath next to PCWriteCond, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  // Next-state logic. run is only looked at in IDLE and on the retire
  // cycle, so dropping it mid-instruction lets the instruction finish.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = HALT;
        endcase
      end
      MEMADR: state_d = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = run ? FETCH : IDLE;
        end
      end
      EXEC:   state_d = RWB;
`ifdef MC_ADDI_EN
      ADDIEX: state_d = ADDIWB;
      ADDIWB: begin
        retire  = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
`endif
      MEMWB, RWB, BEQ, JUMP: begin
        retire  = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state. Because state_q is
  // cleared asynchronously, MemRead/MemWrite drop as soon as reset_n falls.
  // IRWrite/PCWrite in FETCH follow mem_ready so the IR and PC update only
  // on the cycle the fetch completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    PCSource    = '0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) illegal_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Each instruction is expanded by the
// bench into the list of phases it must visit (from its opcode and the
// number of wait cycles chosen for it), and every cycle the DUT state,
// the full control vector, illegal_op and instr_count are compared.

module tb_multicycle_control;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [5:0]  Opcode;
  logic        mem_ready;
  logic        Zero;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal_op;
  logic [15:0] instr_count;

`ifdef MC_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  ctrl_t ctrl_obs;
  assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_count;
  bit          exp_illegal;

  multicycle_control dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .Opcode      (Opcode),
    .mem_ready   (mem_ready),
    .Zero        (Zero),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control table of the sequencer, phase by phase.
  function automatic ctrl_t exp_ctrl(input int st, input bit mr);
    ctrl_t c;
    c = '0;
    case (st)
      1:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      2:  c.alu_src_b = 2'b11;
      3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
      5:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      6:  begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
      7:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      8:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      9:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      10: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      11: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      12: c.reg_write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: called at a falling edge, drives mem_ready, checks
  // every output shortly after, then waits for the next falling edge.
  task automatic step(input int st, input bit mr);
    mem_ready = mr;
    #1;
    check("state", 32'(state), st);
    check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(st, mr)));
    check("illegal_op", 32'(illegal_op), 32'(exp_illegal));
    check("instr_count", 32'(instr_count), 32'(exp_count));
    @(negedge clock);
  endtask

  // Runs one instruction starting in FETCH. fw/mw = wait cycles with
  // mem_ready low in FETCH and in the data-memory phase. With drop_run
  // set, run goes low right after fetch starts and the FSM must still
  // complete the instruction before parking in IDLE.
  task automatic exec_instr(input logic [5:0] op, input int fw, input int mw, input bit drop_run);
    int sts[$];
    bit mrs[$];
    bit retires;
    retires = 1'b1;
    for (int i = 0; i < fw; i++) begin sts.push_back(1); mrs.push_back(1'b0); end
    sts.push_back(1); mrs.push_back(1'b1);
    sts.push_back(2); mrs.push_back(1'($urandom));
    case (op)
      OP_R:   begin sts.push_back(7); mrs.push_back(1'($urandom));
                    sts.push_back(8); mrs.push_back(1'($urandom)); end
      OP_LW:  begin sts.push_back(3); mrs.push_back(1'($urandom));
                    for (int i = 0; i < mw; i++) begin sts.push_back(4); mrs.push_back(1'b0); end
                    sts.push_back(4); mrs.push_back(1'b1);
                    sts.push_back(5); mrs.push_back(1'($urandom)); end
      OP_SW:  begin sts.push_back(3); mrs.push_back(1'($urandom));
                    for (int i = 0; i < mw; i++) begin sts.push_back(6); mrs.push_back(1'b0); end
                    sts.push_back(6); mrs.push_back(1'b1); end
      OP_BEQ: begin sts.push_back(9);  mrs.push_back(1'($urandom)); end
      OP_J:   begin sts.push_back(10); mrs.push_back(1'($urandom)); end
      OP_ADDI: begin
        if (ADDI_EN) begin
          sts.push_back(11); mrs.push_back(1'($urandom));
          sts.push_back(12); mrs.push_back(1'($urandom));
        end else begin
          sts.push_back(13); mrs.push_back(1'($urandom)); retires = 1'b0;
        end
      end
      default: begin sts.push_back(13); mrs.push_back(1'($urandom)); retires = 1'b0; end
    endcase
    Opcode = op;
    foreach (sts[i]) begin
      run = (drop_run && i >= 1) ? 1'b0 : 1'b1;
      if (sts[i] == 13) exp_illegal = 1'b1;
      step(sts[i], mrs[i]);
    end
    if (retires) exp_count = exp_count + 16'd1;
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    exp_count   = '0;
    exp_illegal = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_ctrl", 32'(ctrl_obs), 0);
    check("rst_illegal", 32'(illegal_op), 0);
    check("rst_count", 32'(instr_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    run     = 1'b0;
  endtask

  logic [5:0] ops [6];

  initial begin
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    reset_n     = 1'b0;
    run         = 1'b0;
    mem_ready   = 1'b0;
    Opcode      = '0;
    Zero        = 1'b0;
    exp_count   = '0;
    exp_illegal = 1'b0;
    repeat (2) @(negedge clock);

    // Reset values, then idle with run low.
    step(0, 1'b1);
    reset_n = 1'b1;
    step(0, 1'b1);
    run = 1'b1;
    step(0, 1'b1);

    // R-type, lw with 2 fetch waits and 1 read wait (8 cycles), beq, j.
    exec_instr(OP_R, 0, 0, 1'b0);
    exec_instr(OP_LW, 2, 1, 1'b0);
    exec_instr(OP_BEQ, 0, 0, 1'b0);
    exec_instr(OP_J, 0, 0, 1'b0);

    // Randomised instruction mix with random wait states.
    repeat (40) begin
      int k;
      k = int'($urandom_range(0, ADDI_EN ? 5 : 4));
      Zero = 1'($urandom);
      exec_instr(ops[k], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    // addi: retires in 4 cycles when built in, otherwise halts.
    exec_instr(OP_ADDI, 0, 0, 1'b0);
    if (!ADDI_EN) begin
      do_reset();
      run = 1'b1;
      step(0, 1'b1);
    end

    // sw with run dropped mid-instruction: completes, then IDLE.
    exec_instr(OP_SW, 0, 2, 1'b1);
    step(0, 1'b1);

    // Counter wrap: preload 0xFFFF while idle, retire one j.
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    exp_count = 16'hFFFF;
    check("preload", 32'(instr_count), 32'h0000FFFF);
    run = 1'b1;
    step(0, 1'b0);
    exec_instr(OP_J, 0, 0, 1'b1);
    step(0, 1'b1);

    // Reset while a load waits in MEMRD: MemRead must drop before the edge.
    run    = 1'b1;
    Opcode = OP_LW;
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    step(3, 1'b1);
    mem_ready = 1'b0;
    #1;
    check("memrd_state", 32'(state), 4);
    check("memrd_read", 32'(MemRead), 1);
    #2 reset_n = 1'b0;
    #1;
    exp_count = '0;
    check("arst_read", 32'(MemRead), 0);
    check("arst_write", 32'(MemWrite), 0);
    check("arst_regwrite", 32'(RegWrite), 0);
    check("arst_state", 32'(state), 0);
    check("arst_count", 32'(instr_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    run     = 1'b0;
    step(0, 1'b1);

    // Illegal opcode after one good instruction: HALT is absorbing.
    run = 1'b1;
    step(0, 1'b1);
    exec_instr(OP_R, 0, 0, 1'b0);
    exec_instr(OP_BAD, 1, 0, 1'b0);
    repeat (20) begin
      run = 1'($urandom);
      step(13, 1'($urandom));
    end
    do_reset();
    step(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
